// File: rtl/cp0_unit.sv
// Coprocessor-0 for the five-stage pipeline: SR, Cause, EPC and PRID registers,
// exception/interrupt request generation and mtc0/mfc0/eret handling.
module cp0_unit #(
    parameter logic [31:0] PRID = 32'h2023_0007
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [4:0]  CP0Add,
    input  logic [31:0] CP0In,
    output logic [31:0] CP0Out,
    input  logic [31:0] VPC,
    input  logic        BDIn,
    input  logic [4:0]  ExcCodeIn,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
    output logic [31:0] EPCOut,
    output logic        Req
);

    localparam logic [4:0] ADDR_SR    = 5'd12;
    localparam logic [4:0] ADDR_CAUSE = 5'd13;
    localparam logic [4:0] ADDR_EPC   = 5'd14;
    localparam logic [4:0] ADDR_PRID  = 5'd15;

    logic [5:0]  sr_im_q,       sr_im_d;
    logic        sr_exl_q,      sr_exl_d;
    logic        sr_ie_q,       sr_ie_d;
    logic        cause_bd_q,    cause_bd_d;
    logic [5:0]  cause_ip_q,    cause_ip_d;
    logic [4:0]  cause_exc_q,   cause_exc_d;
    logic [31:0] epc_q,         epc_d;

    logic        int_req;
    logic        exc_req;
    logic [31:0] sr_val;
    logic [31:0] cause_val;

    assign int_req = (|(HWInt & sr_im_q)) & sr_ie_q & ~sr_exl_q;
    assign exc_req = (ExcCodeIn != 5'd0) & ~sr_exl_q;
    assign Req     = int_req | exc_req;

    assign sr_val    = {16'd0, sr_im_q, 8'd0, sr_exl_q, sr_ie_q};
    assign cause_val = {cause_bd_q, 15'd0, cause_ip_q, 3'd0, cause_exc_q, 2'd0};
    assign EPCOut    = epc_q;

    always_comb begin
        CP0Out = 32'd0;
        case (CP0Add)
            ADDR_SR:    CP0Out = sr_val;
            ADDR_CAUSE: CP0Out = cause_val;
            ADDR_EPC:   CP0Out = epc_q;
            ADDR_PRID:  CP0Out = PRID;
            default:    CP0Out = 32'd0;
        endcase
    end

    always_comb begin
        // NOTE: every _d gets its hold value first so no path can infer a latch.
        sr_im_d     = sr_im_q;
        sr_exl_d    = sr_exl_q;
        sr_ie_d     = sr_ie_q;
        cause_bd_d  = cause_bd_q;
        cause_exc_d = cause_exc_q;
        epc_d       = epc_q;
        cause_ip_d  = HWInt;

        if (Req) begin
            // Taking the exception discards any mtc0 and eret in flight.
            sr_exl_d    = 1'b1;
            cause_exc_d = int_req ? 5'd0 : ExcCodeIn;
            cause_bd_d  = BDIn;
            epc_d       = BDIn ? (VPC - 32'd4) : VPC;
        end else begin
            if (en && CP0Add == ADDR_SR) begin
                sr_im_d  = CP0In[15:10];
                sr_exl_d = CP0In[1];
                sr_ie_d  = CP0In[0];
            end
            if (en && CP0Add == ADDR_EPC) begin
                epc_d = CP0In;
            end
            // eret is applied last so it clears EXL even against an SR write.
            if (EXLClr) begin
                sr_exl_d = 1'b0;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            sr_im_q     <= 6'd0;
            sr_exl_q    <= 1'b0;
            sr_ie_q     <= 1'b0;
            cause_bd_q  <= 1'b0;
            cause_ip_q  <= 6'd0;
            cause_exc_q <= 5'd0;
            epc_q       <= 32'd0;
        end else begin
            sr_im_q     <= sr_im_d;
            sr_exl_q    <= sr_exl_d;
            sr_ie_q     <= sr_ie_d;
            cause_bd_q  <= cause_bd_d;
            cause_ip_q  <= cause_ip_d;
            cause_exc_q <= cause_exc_d;
            epc_q       <= epc_d;
        end
    end

endmodule

// File: tb/tb_cp0_unit.sv
// Directed-vector bench for cp0_unit with hand-computed expected register values.
module tb_cp0_unit;

    localparam logic [31:0] PRID_VAL = 32'h2023_0007;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [4:0]  CP0Add;
    logic [31:0] CP0In;
    logic [31:0] CP0Out;
    logic [31:0] VPC;
    logic        BDIn;
    logic [4:0]  ExcCodeIn;
    logic [5:0]  HWInt;
    logic        EXLClr;
    logic [31:0] EPCOut;
    logic        Req;

    int n_vec = 0;
    int n_err = 0;

    cp0_unit #(.PRID(PRID_VAL)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .CP0Add    (CP0Add),
        .CP0In     (CP0In),
        .CP0Out    (CP0Out),
        .VPC       (VPC),
        .BDIn      (BDIn),
        .ExcCodeIn (ExcCodeIn),
        .HWInt     (HWInt),
        .EXLClr    (EXLClr),
        .EPCOut    (EPCOut),
        .Req       (Req)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reg(input string tag, input logic [4:0] addr, input logic [31:0] exp);
        CP0Add = addr;
        #1;
        check(tag, CP0Out, exp);
    endtask

    task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
        en = 1'b1; CP0Add = addr; CP0In = data;
        tick();
        en = 1'b0;
    endtask

    task automatic eret();
        EXLClr = 1'b1;
        tick();
        EXLClr = 1'b0;
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; CP0Add = 5'd0; CP0In = 32'd0; VPC = 32'd0;
        BDIn = 1'b0; ExcCodeIn = 5'd0; HWInt = 6'd0; EXLClr = 1'b0;
        tick(); tick();
        reset = 1'b0;
        #1;

        // Reset state
        check("rst_req", {31'd0, Req}, 32'd0);
        check("rst_epcout", EPCOut, 32'd0);
        check_reg("rst_sr", 5'd12, 32'd0);
        check_reg("rst_cause", 5'd13, 32'd0);
        check_reg("rst_epc", 5'd14, 32'd0);
        check_reg("rst_prid", 5'd15, PRID_VAL);
        check_reg("unmapped_rd", 5'd3, 32'd0);

        // Interrupt: SR=fc01 then HWInt[2]
        mtc0(5'd12, 32'h0000_fc01);
        check_reg("sr_write", 5'd12, 32'h0000_fc01);
        VPC = 32'h0000_3000; HWInt = 6'b000100;
        #1;
        check("int_req", {31'd0, Req}, 32'd1);
        tick();
        check_reg("int_cause", 5'd13, 32'h0000_1000);
        check_reg("int_epc", 5'd14, 32'h0000_3000);
        check_reg("int_sr", 5'd12, 32'h0000_fc03);
        check("int_req_drop", {31'd0, Req}, 32'd0);
        HWInt = 6'd0;
        eret();
        check_reg("eret_sr", 5'd12, 32'h0000_fc01);

        // Exception in a delay slot
        ExcCodeIn = 5'd4; BDIn = 1'b1; VPC = 32'h0000_3010;
        #1;
        check("exc_req", {31'd0, Req}, 32'd1);
        tick();
        ExcCodeIn = 5'd0; BDIn = 1'b0;
        check("bd_epcout", EPCOut, 32'h0000_300c);
        check_reg("bd_cause", 5'd13, 32'h8000_0010);

        // No nesting while EXL=1, then eret releases the pending exception
        ExcCodeIn = 5'd12; VPC = 32'h0000_5000; HWInt = 6'h3f;
        #1;
        check("exl_block_req", {31'd0, Req}, 32'd0);
        HWInt = 6'd0;
        tick();
        check_reg("exl_hold_epc", 5'd14, 32'h0000_300c);
        check_reg("exl_hold_cause", 5'd13, 32'h8000_0010);
        eret();
        check_reg("exl_clr_sr", 5'd12, 32'h0000_fc01);
        check("pending_req", {31'd0, Req}, 32'd1);
        tick();
        ExcCodeIn = 5'd0;
        check_reg("pending_cause", 5'd13, 32'h0000_0030);
        check_reg("pending_epc", 5'd14, 32'h0000_5000);

        // Interrupt beats a simultaneous exception
        eret();
        HWInt = 6'b000001; ExcCodeIn = 5'd10; VPC = 32'h0000_6000;
        #1;
        check("prio_req", {31'd0, Req}, 32'd1);
        tick();
        HWInt = 6'd0; ExcCodeIn = 5'd0;
        check_reg("prio_cause", 5'd13, 32'h0000_0400);
        check_reg("prio_epc", 5'd14, 32'h0000_6000);

        // mtc0 dropped when Req fires; Cause and PRID are not writable
        eret();
        ExcCodeIn = 5'd8; VPC = 32'h0000_3020;
        en = 1'b1; CP0Add = 5'd14; CP0In = 32'h0000_3400;
        tick();
        en = 1'b0; ExcCodeIn = 5'd0;
        check_reg("drop_epc", 5'd14, 32'h0000_3020);
        check_reg("drop_cause", 5'd13, 32'h0000_0020);
        mtc0(5'd13, 32'hffff_ffff);
        check_reg("cause_ro", 5'd13, 32'h0000_0020);
        mtc0(5'd15, 32'h1234_5678);
        check_reg("prid_ro", 5'd15, PRID_VAL);

        // eret together with an SR write: EXL forced to 0
        EXLClr = 1'b1;
        mtc0(5'd12, 32'h0000_0403);
        EXLClr = 1'b0;
        check_reg("eret_sr_write", 5'd12, 32'h0000_0401);

        // No write-to-read bypass
        en = 1'b1; CP0Add = 5'd14; CP0In = 32'hdead_beef;
        #1;
        check("no_bypass", CP0Out, 32'h0000_3020);
        tick();
        en = 1'b0;
        check("epc_written", EPCOut, 32'hdead_beef);

        // EPC wrap-around on VPC=0 in a delay slot
        ExcCodeIn = 5'd1; BDIn = 1'b1; VPC = 32'd0;
        tick();
        ExcCodeIn = 5'd0; BDIn = 1'b0;
        check("wrap_epc", EPCOut, 32'hffff_fffc);
        check_reg("wrap_sr", 5'd12, 32'h0000_0403);

        // Reset mid-exception overrides a write, eret and interrupt lines
        reset = 1'b1; HWInt = 6'h3f; EXLClr = 1'b1;
        en = 1'b1; CP0Add = 5'd12; CP0In = 32'h0000_fc01;
        tick();
        en = 1'b0; EXLClr = 1'b0;
        check_reg("mid_rst_sr", 5'd12, 32'd0);
        check_reg("mid_rst_cause", 5'd13, 32'd0);
        check_reg("mid_rst_epc", 5'd14, 32'd0);
        check_reg("mid_rst_prid", 5'd15, PRID_VAL);
        check("mid_rst_req", {31'd0, Req}, 32'd0);
        reset = 1'b0; HWInt = 6'd0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/cp0_unit.md
CP0_UNIT -- requirements
Module: cp0_unit

Interface
REQ-001 The block SHALL have parameter PRID, default 32'h2023_0007, holding the read-only processor-ID value returned at register 15.
REQ-002 The block SHALL have port clk, input, 1 bit: clock, all state changes on the rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port en, input, 1 bit: mtc0 write strobe from the M stage.
REQ-005 The block SHALL have port CP0Add, input, 5 bits: register number for both read and write.
REQ-006 The block SHALL have port CP0In, input, 32 bits: mtc0 write data.
REQ-007 The block SHALL have port CP0Out, output, 32 bits: mfc0 read data, combinational from the addressed register.
REQ-008 The block SHALL have port VPC, input, 32 bits: PC of the instruction currently in M.
REQ-009 The block SHALL have port BDIn, input, 1 bit: M instruction sits in a branch delay slot.
REQ-010 The block SHALL have port ExcCodeIn, input, 5 bits: exception code of the M instruction; 0 means none.
REQ-011 The block SHALL have port HWInt, input, 6 bits: external interrupt lines, level-sensitive.
REQ-012 The block SHALL have port EXLClr, input, 1 bit: eret in M.
REQ-013 The block SHALL have port EPCOut, output, 32 bits: current EPC register, used as the eret target.
REQ-014 The block SHALL have port Req, output, 1 bit: exception/interrupt request; drives the flush and handler-PC (0x0000_4180) load of all pipeline registers.

Function
REQ-015 The block SHALL define SR (register 12) as IM=[15:10], EXL=[1], IE=[0]; all other SR bits SHALL read 0.
REQ-016 The block SHALL define Cause (register 13) as BD=[31], IP=[15:10], ExcCode=[6:2]; all other Cause bits SHALL read 0.
REQ-017 The block SHALL define EPC (register 14) as 32 bits, and register 15 SHALL read PRID.
REQ-018 Reads of any other CP0Add SHALL return 0.
REQ-019 The block SHALL compute IntReq = |(HWInt & SR.IM) & SR.IE & ~SR.EXL, combinationally.
REQ-020 The block SHALL compute ExcReq = (ExcCodeIn != 0) & ~SR.EXL, combinationally.
REQ-021 Req SHALL equal IntReq | ExcReq, combinationally in the same cycle, with no added latency.
REQ-022 On a clock edge with Req=1, SR.EXL SHALL become 1.
REQ-023 On a clock edge with Req=1, Cause.ExcCode SHALL become 0 if IntReq=1, else ExcCodeIn; an interrupt has priority over a simultaneous exception.
REQ-024 On a clock edge with Req=1, Cause.BD SHALL become BDIn.
REQ-025 On a clock edge with Req=1, EPC SHALL become VPC-4 if BDIn=1, else VPC; the subtraction is 32-bit with wrap-around, no alignment masking.
REQ-026 Cause.IP SHALL load HWInt on every clock edge when reset=0, regardless of Req.
REQ-027 With en=1 and Req=0, CP0Add=12 SHALL write IM, EXL and IE from CP0In; CP0Add=14 SHALL write EPC from CP0In.
REQ-028 mtc0 writes to Cause, register 15 or unmapped addresses SHALL be ignored.
REQ-029 When Req=1 in the same cycle as en=1, the mtc0 write SHALL be discarded.
REQ-030 With EXLClr=1 and Req=0, SR.EXL SHALL clear to 0 at the edge.
REQ-031 With EXLClr=1 and Req=1, Req wins and EXL SHALL end at 1.
REQ-032 When EXLClr=1 coincides with an en=1 write to SR, SR SHALL take the written IM and IE, with EXL=0.
REQ-033 CP0Out SHALL reflect register contents before the edge; there SHALL be no write-to-read bypass.
REQ-034 EPCOut SHALL always equal the EPC register.
REQ-035 While EXL=1, Req SHALL remain 0 irrespective of HWInt and ExcCodeIn (no nested exceptions).

Reset
REQ-036 On reset=1 at a clock edge, SR, Cause and EPC SHALL all become 0.
REQ-037 After reset, Req=0, EPCOut=0, and CP0Out reads 0 for registers 12, 13 and 14 and PRID for register 15.
REQ-038 Reset SHALL override Req, en and EXLClr in the same cycle, including reset asserted mid-exception (EXL=1).

Verification
REQ-039 Scenario: reset; write SR=32'h0000_fc01; then HWInt=6'b000100 -> Req=1 in the same cycle; next edge Cause=32'h0000_1000, EPC=VPC, SR=32'h0000_fc03, Req drops to 0.
REQ-040 Scenario: ExcCodeIn=5'd4, BDIn=1, VPC=32'h0000_3010 -> Req=1; after the edge EPC=32'h0000_300c, Cause=32'h8000_0010.
REQ-041 Scenario: IE=1, IM=6'h3f, HWInt=1, ExcCodeIn=5'd10 in the same cycle -> Cause.ExcCode=0 (interrupt wins), EPC=VPC.
REQ-042 Scenario: EXL=1, ExcCodeIn=5'd12 -> Req=0 and registers unchanged; then EXLClr=1 -> EXL=0, and the still-present ExcCodeIn gives Req=1 next cycle.
REQ-043 Scenario: en=1, CP0Add=14, CP0In=32'h0000_3400 together with Req=1 from VPC=32'h0000_3020 -> EPC=32'h0000_3020 (write dropped); en=1, CP0Add=13 -> Cause unchanged.
REQ-044 Scenario: reset asserted while EXL=1 and EPC nonzero -> all registers 0 next edge; CP0Add=15 reads PRID.
